rbus_vo_cfg_ctrl: RTL and testbench

- Event-side configuration controller for the next-generation multi-layer video-out path.
- Decodes ring events into per-layer shadow registers, then commits them to active registers atomically at frame start (tear-free).
- Buffers PUT_CHAR events in a FIFO and answers register read-back requests through the d2r event channel.
- Sits between the ring device port and the multi-layer video-out engine; all logic runs in the clk domain.

---
 rtl/rbus_vo_pkg.sv | 32 +++
 rtl/rbus_vo_char_fifo.sv | 55 +++++
 rtl/rbus_vo_cfg_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_rbus_vo_cfg_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbus_vo_pkg.sv
// Shared definitions for the ring-bus video-out configuration controller:
// event command codes, reset defaults and the controller state enums.
package rbus_vo_pkg;

    localparam logic [7:0] CMD_BASE_ADDR = 8'h20;
    localparam logic [7:0] CMD_PH_WIDTH  = 8'h21;
    localparam logic [7:0] CMD_LO_WIDTH  = 8'h22;
    localparam logic [7:0] CMD_LO_HEIGHT = 8'h23;
    localparam logic [7:0] CMD_MODE      = 8'h24;
    localparam logic [7:0] CMD_TEXT_ENA  = 8'h25;
    localparam logic [7:0] CMD_PUT_CHAR  = 8'h26;
    localparam logic [7:0] CMD_H_POL     = 8'h27;
    localparam logic [7:0] CMD_V_POL     = 8'h28;
    localparam logic [7:0] CMD_LAYER_ENA = 8'h29;
    localparam logic [7:0] CMD_COMMIT    = 8'h2A;
    localparam logic [7:0] CMD_READ_REG  = 8'h2B;
    localparam logic [7:0] CMD_SEL_LAYER = 8'h2C;
    localparam logic [7:0] CMD_REPLY     = 8'h2F;

    localparam logic [15:0] PH_WIDTH_RST = 16'd2048;

    typedef enum logic {
        COMMIT_IDLE,
        COMMIT_ARMED
    } commit_state_t;

    typedef enum logic {
        REPLY_IDLE,
        REPLY_BUSY
    } reply_state_t;

endpackage

// File: rtl/rbus_vo_char_fifo.sv
// Synchronous FIFO holding PUT_CHAR bytes until the video-out engine pops them.
module rbus_vo_char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] pop_data_o
);
    import rbus_vo_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i & ~full_o;
    assign pop_ok     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rbus_vo_cfg_ctrl.sv
// Ring-event configuration controller for the multi-layer video-out path.
// Per-layer settings land in shadow registers and are copied to the active
// set at the first frame start after a COMMIT; global settings apply at once.
module rbus_vo_cfg_ctrl #(
    parameter int unsigned NUM_LAYERS       = 2,
    parameter int unsigned CHAR_FIFO_DEPTH  = 16,
    parameter logic [7:0]  DEV_ID           = 8'h00,
    parameter logic [38:0] MEM_BUFF_START   = 39'h0,
    parameter int unsigned MAX_DISP_L_WIDTH = 480,
    parameter int unsigned MAX_DISP_HEIGHT  = 272,
    parameter logic        H_SYNC_POL       = 1'b0,
    parameter logic        V_SYNC_POL       = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       soft_rst,
    input  logic                       frame_start,
    input  logic                       r2d_eve_stb,
    input  logic [7:0]                 r2d_eve_cmd,
    input  logic [39:0]                r2d_eve_ptr,
    output logic                       r2d_eve_ack,
    output logic                       d2r_eve_stb,
    output logic [7:0]                 d2r_eve_cmd,
    output logic [7:0]                 d2r_eve_dev,
    output logic [39:0]                d2r_eve_ptr,
    input  logic                       d2r_eve_ack,
    output logic [39*NUM_LAYERS-1:0]   cfg_base_addr,
    output logic [16*NUM_LAYERS-1:0]   cfg_ph_width,
    output logic [16*NUM_LAYERS-1:0]   cfg_lo_width,
    output logic [16*NUM_LAYERS-1:0]   cfg_lo_height,
    output logic [2*NUM_LAYERS-1:0]    cfg_mode,
    output logic [NUM_LAYERS-1:0]      cfg_layer_ena,
    output logic                       cfg_text_ena,
    output logic                       cfg_h_pol,
    output logic                       cfg_v_pol,
    output logic                       char_stb,
    output logic [7:0]                 char_dat,
    input  logic                       char_ack
);
    import rbus_vo_pkg::*;

    localparam logic [15:0] LO_WIDTH_RST  = 16'(MAX_DISP_L_WIDTH);
    localparam logic [15:0] LO_HEIGHT_RST = 16'(MAX_DISP_HEIGHT);

    logic [38:0] shd_base_q [NUM_LAYERS];
    logic [15:0] shd_ph_q   [NUM_LAYERS];
    logic [15:0] shd_lw_q   [NUM_LAYERS];
    logic [15:0] shd_lh_q   [NUM_LAYERS];
    logic [1:0]  shd_mode_q [NUM_LAYERS];
    logic        shd_ena_q  [NUM_LAYERS];
    logic [38:0] act_base_q [NUM_LAYERS];
    logic [15:0] act_ph_q   [NUM_LAYERS];
    logic [15:0] act_lw_q   [NUM_LAYERS];
    logic [15:0] act_lh_q   [NUM_LAYERS];
    logic [1:0]  act_mode_q [NUM_LAYERS];
    logic        act_ena_q  [NUM_LAYERS];

    logic [2:0]    layer_sel_q;
    logic          text_ena_q;
    logic          h_pol_q;
    logic          v_pol_q;
    commit_state_t commit_q;
    reply_state_t  reply_q;

    logic        rst_all;
    logic        is_put;
    logic        is_read;
    logic        fifo_full;
    logic        fifo_empty;
    logic [39:0] rd_val;
    logic [2:0]  rd_layer;
    logic [7:0]  rd_code;
    logic        unused_ptr_msb;

    assign rst_all        = rst | soft_rst;
    assign is_put         = (r2d_eve_cmd == CMD_PUT_CHAR);
    assign is_read        = (r2d_eve_cmd == CMD_READ_REG);
    assign r2d_eve_ack    = r2d_eve_stb & ~(is_put & fifo_full)
                                        & ~(is_read & (reply_q == REPLY_BUSY));
    assign rd_code        = r2d_eve_ptr[7:0];
    assign rd_layer       = r2d_eve_ptr[10:8];
    assign unused_ptr_msb = r2d_eve_ptr[39];
    assign char_stb       = ~fifo_empty;

    rbus_vo_char_fifo #(
        .DEPTH (CHAR_FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk         (clk),
        .rst         (rst_all),
        .push_i      (r2d_eve_ack & is_put),
        .push_data_i (r2d_eve_ptr[7:0]),
        .full_o      (fifo_full),
        .pop_i       (char_ack),
        .empty_o     (fifo_empty),
        .pop_data_o  (char_dat)
    );

    // Shadow/active register file, global settings and the commit FSM.
    // The frame-start copy reads shadows before this cycle's event write lands,
    // so a write coinciding with the copy is held back for the next commit.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                shd_base_q[i] <= MEM_BUFF_START;
                shd_ph_q[i]   <= PH_WIDTH_RST;
                shd_lw_q[i]   <= LO_WIDTH_RST;
                shd_lh_q[i]   <= LO_HEIGHT_RST;
                shd_mode_q[i] <= '0;
                shd_ena_q[i]  <= (i == 0);
                act_base_q[i] <= MEM_BUFF_START;
                act_ph_q[i]   <= PH_WIDTH_RST;
                act_lw_q[i]   <= LO_WIDTH_RST;
                act_lh_q[i]   <= LO_HEIGHT_RST;
                act_mode_q[i] <= '0;
                act_ena_q[i]  <= (i == 0);
            end
            layer_sel_q <= '0;
            text_ena_q  <= 1'b0;
            h_pol_q     <= H_SYNC_POL;
            v_pol_q     <= V_SYNC_POL;
            commit_q    <= COMMIT_IDLE;
        end else begin
            case (commit_q)
                COMMIT_IDLE: begin
                    if (r2d_eve_ack && r2d_eve_cmd == CMD_COMMIT) commit_q <= COMMIT_ARMED;
                end
                COMMIT_ARMED: begin
                    if (frame_start) begin
                        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                            act_base_q[i] <= shd_base_q[i];
                            act_ph_q[i]   <= shd_ph_q[i];
                            act_lw_q[i]   <= shd_lw_q[i];
                            act_lh_q[i]   <= shd_lh_q[i];
                            act_mode_q[i] <= shd_mode_q[i];
                            act_ena_q[i]  <= shd_ena_q[i];
                        end
                        commit_q <= COMMIT_IDLE;
                    end
                end
                default: commit_q <= COMMIT_IDLE;
            endcase

            if (r2d_eve_ack) begin
                case (r2d_eve_cmd)
                    CMD_TEXT_ENA:  text_ena_q <= r2d_eve_ptr[0];
                    CMD_H_POL:     h_pol_q    <= r2d_eve_ptr[0];
                    CMD_V_POL:     v_pol_q    <= r2d_eve_ptr[0];
                    CMD_SEL_LAYER: begin
                        if ({1'b0, r2d_eve_ptr[2:0]} < 4'(NUM_LAYERS))
                            layer_sel_q <= r2d_eve_ptr[2:0];
                    end
                    default: begin
                        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                            if (layer_sel_q == 3'(i)) begin
                                case (r2d_eve_cmd)
                                    CMD_BASE_ADDR: shd_base_q[i] <= r2d_eve_ptr[38:0];
                                    CMD_PH_WIDTH:  shd_ph_q[i]   <= {4'b0, r2d_eve_ptr[11:0]};
                                    CMD_LO_WIDTH:  shd_lw_q[i]   <= {4'b0, r2d_eve_ptr[11:0]};
                                    CMD_LO_HEIGHT: shd_lh_q[i]   <= {4'b0, r2d_eve_ptr[11:0]};
                                    CMD_MODE:      shd_mode_q[i] <= r2d_eve_ptr[1:0];
                                    CMD_LAYER_ENA: shd_ena_q[i]  <= r2d_eve_ptr[0];
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Read-back selector over the active set; unknown codes or layers read 0.
    always_comb begin
        rd_val = '0;
        case (rd_code)
            CMD_TEXT_ENA: rd_val = {39'b0, text_ena_q};
            CMD_H_POL:    rd_val = {39'b0, h_pol_q};
            CMD_V_POL:    rd_val = {39'b0, v_pol_q};
            default: begin
                for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                    if (rd_layer == 3'(i)) begin
                        case (rd_code)
                            CMD_BASE_ADDR: rd_val = {1'b0, act_base_q[i]};
                            CMD_PH_WIDTH:  rd_val = {24'b0, act_ph_q[i]};
                            CMD_LO_WIDTH:  rd_val = {24'b0, act_lw_q[i]};
                            CMD_LO_HEIGHT: rd_val = {24'b0, act_lh_q[i]};
                            CMD_MODE:      rd_val = {38'b0, act_mode_q[i]};
                            CMD_LAYER_ENA: rd_val = {39'b0, act_ena_q[i]};
                            default:       rd_val = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Reply FSM: capture the read value on an accepted READ_REG, hold until acked.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            reply_q     <= REPLY_IDLE;
            d2r_eve_stb <= 1'b0;
            d2r_eve_cmd <= '0;
            d2r_eve_dev <= '0;
            d2r_eve_ptr <= '0;
        end else begin
            case (reply_q)
                REPLY_IDLE: begin
                    if (r2d_eve_ack && is_read) begin
                        reply_q     <= REPLY_BUSY;
                        d2r_eve_stb <= 1'b1;
                        d2r_eve_cmd <= CMD_REPLY;
                        d2r_eve_dev <= DEV_ID;
                        d2r_eve_ptr <= rd_val;
                    end
                end
                REPLY_BUSY: begin
                    if (d2r_eve_ack) begin
                        reply_q     <= REPLY_IDLE;
                        d2r_eve_stb <= 1'b0;
                    end
                end
                default: reply_q <= REPLY_IDLE;
            endcase
        end
    end

    // Flatten the active per-layer registers onto the output buses.
    always_comb begin
        cfg_base_addr = '0;
        cfg_ph_width  = '0;
        cfg_lo_width  = '0;
        cfg_lo_height = '0;
        cfg_mode      = '0;
        cfg_layer_ena = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            cfg_base_addr[39*i +: 39] = act_base_q[i];
            cfg_ph_width[16*i +: 16]  = act_ph_q[i];
            cfg_lo_width[16*i +: 16]  = act_lw_q[i];
            cfg_lo_height[16*i +: 16] = act_lh_q[i];
            cfg_mode[2*i +: 2]        = act_mode_q[i];
            cfg_layer_ena[i]          = act_ena_q[i];
        end
    end

    assign cfg_text_ena = text_ena_q;
    assign cfg_h_pol    = h_pol_q;
    assign cfg_v_pol    = v_pol_q;

endmodule

// File: tb/tb_rbus_vo_cfg_ctrl.sv
// Self-checking bench for rbus_vo_cfg_ctrl: directed corner sequences,
// a read-back vector table and a randomized run against a reference model.
module tb_rbus_vo_cfg_ctrl;

    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1, soft_rst = 1'b0, frame_start = 1'b0;
    logic r2d_stb = 1'b0;
    logic [7:0] r2d_cmd = '0;
    logic [39:0] r2d_ptr = '0;
    logic r2d_ack;
    logic d2r_stb;
    logic [7:0] d2r_cmd, d2r_dev;
    logic [39:0] d2r_ptr;
    logic d2r_ack = 1'b0;
    logic [39*NL-1:0] cfg_base_addr;
    logic [16*NL-1:0] cfg_ph_width, cfg_lo_width, cfg_lo_height;
    logic [2*NL-1:0] cfg_mode;
    logic [NL-1:0] cfg_layer_ena;
    logic cfg_text_ena, cfg_h_pol, cfg_v_pol;
    logic char_stb;
    logic [7:0] char_dat;
    logic char_ack = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rbus_vo_cfg_ctrl #(
        .NUM_LAYERS(NL), .CHAR_FIFO_DEPTH(16), .DEV_ID(8'hA5),
        .MEM_BUFF_START(39'h0), .MAX_DISP_L_WIDTH(480), .MAX_DISP_HEIGHT(272),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .frame_start(frame_start),
        .r2d_eve_stb(r2d_stb), .r2d_eve_cmd(r2d_cmd), .r2d_eve_ptr(r2d_ptr),
        .r2d_eve_ack(r2d_ack),
        .d2r_eve_stb(d2r_stb), .d2r_eve_cmd(d2r_cmd), .d2r_eve_dev(d2r_dev),
        .d2r_eve_ptr(d2r_ptr), .d2r_eve_ack(d2r_ack),
        .cfg_base_addr(cfg_base_addr), .cfg_ph_width(cfg_ph_width),
        .cfg_lo_width(cfg_lo_width), .cfg_lo_height(cfg_lo_height),
        .cfg_mode(cfg_mode), .cfg_layer_ena(cfg_layer_ena),
        .cfg_text_ena(cfg_text_ena), .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .char_stb(char_stb), .char_dat(char_dat), .char_ack(char_ack)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One event cycle: present, check the combinational ack, let the edge pass.
    task automatic send(input logic [7:0] c, input logic [39:0] p, input logic exp_ack);
        r2d_stb = 1'b1; r2d_cmd = c; r2d_ptr = p;
        #1;
        chk("r2d_ack", r2d_ack, exp_ack);
        @(posedge clk);
        #1;
        r2d_stb = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [38:0] base;
        logic [15:0] ph, lw, lh;
        logic [1:0]  mode;
        logic        ena;
    } lay_t;

    lay_t m_shd[NL];
    lay_t m_act[NL];
    int   m_sel;
    bit   m_armed, m_busy, m_text, m_hpol, m_vpol;
    logic [39:0] m_rptr;
    logic [7:0]  m_fifo[$];

    function automatic void m_reset();
        for (int l = 0; l < NL; l++) begin
            m_shd[l] = '{base: 39'h0, ph: 16'd2048, lw: 16'd480, lh: 16'd272,
                         mode: 2'd0, ena: (l == 0)};
            m_act[l] = m_shd[l];
        end
        m_sel = 0; m_armed = 0; m_busy = 0; m_text = 0; m_hpol = 0; m_vpol = 0;
        m_fifo.delete();
    endfunction

    function automatic logic [39:0] m_read(input logic [39:0] p);
        int lay = int'(p[10:8]);
        logic [7:0] code = p[7:0];
        if (code == 8'h25) return {39'b0, m_text};
        if (code == 8'h27) return {39'b0, m_hpol};
        if (code == 8'h28) return {39'b0, m_vpol};
        if (lay >= NL) return '0;
        case (code)
            8'h20: return {1'b0, m_act[lay].base};
            8'h21: return {24'b0, m_act[lay].ph};
            8'h22: return {24'b0, m_act[lay].lw};
            8'h23: return {24'b0, m_act[lay].lh};
            8'h24: return {38'b0, m_act[lay].mode};
            8'h29: return {39'b0, m_act[lay].ena};
            default: return '0;
        endcase
    endfunction

    function automatic bit m_ack(input bit stb, input logic [7:0] c);
        return stb && !(c == 8'h26 && m_fifo.size() == 16) && !(c == 8'h2B && m_busy);
    endfunction

    function automatic void m_step(input bit srst, input bit ack, input logic [7:0] c,
                                   input logic [39:0] p, input bit fs, input bit cack,
                                   input bit dack);
        lay_t old_shd[NL];
        logic [39:0] rv;
        bit was_armed;
        if (srst) begin
            m_reset();
            return;
        end
        old_shd = m_shd;
        was_armed = m_armed;
        rv = m_read(p);
        if (cack && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (m_busy && dack) m_busy = 0;
        if (ack) begin
            case (c)
                8'h20: m_shd[m_sel].base = p[38:0];
                8'h21: m_shd[m_sel].ph   = {4'b0, p[11:0]};
                8'h22: m_shd[m_sel].lw   = {4'b0, p[11:0]};
                8'h23: m_shd[m_sel].lh   = {4'b0, p[11:0]};
                8'h24: m_shd[m_sel].mode = p[1:0];
                8'h29: m_shd[m_sel].ena  = p[0];
                8'h25: m_text = p[0];
                8'h27: m_hpol = p[0];
                8'h28: m_vpol = p[0];
                8'h26: m_fifo.push_back(p[7:0]);
                8'h2A: if (!was_armed) m_armed = 1;
                8'h2B: begin m_busy = 1; m_rptr = rv; end
                8'h2C: if (int'(p[2:0]) < NL) m_sel = int'(p[2:0]);
                default: ;
            endcase
        end
        if (was_armed && fs) begin
            m_act = old_shd;
            m_armed = 0;
        end
    endfunction

    // ---------------- read-back vector table ----------------
    typedef struct {
        logic [7:0]  wcmd;
        logic [39:0] wptr;
        logic [10:0] rsel;
        logic [39:0] exp;
    } vec_t;

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        logic [39:0] p;
        bit fs, ca, da, sr, stb, ea;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst d2r_stb", d2r_stb, 0);
        chk("rst d2r_ptr", d2r_ptr, 0);
        chk("rst char_stb", char_stb, 0);
        chk("rst base0", cfg_base_addr[38:0], 0);
        chk("rst base1", cfg_base_addr[77:39], 0);
        chk("rst ph", cfg_ph_width, {16'd2048, 16'd2048});
        chk("rst lw", cfg_lo_width, {16'd480, 16'd480});
        chk("rst lh", cfg_lo_height, {16'd272, 16'd272});
        chk("rst mode", cfg_mode, 0);
        chk("rst ena", cfg_layer_ena, 2'b01);
        chk("rst glob", {cfg_text_ena, cfg_h_pol, cfg_v_pol}, 0);

        // Read-back reply held until acknowledged
        send(8'h2B, 40'h022, 1);
        chk("rd1 stb", d2r_stb, 1);
        chk("rd1 cmd", d2r_cmd, 8'h2F);
        chk("rd1 dev", d2r_dev, 8'hA5);
        chk("rd1 ptr", d2r_ptr, 480);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd1 hold", d2r_stb, 1);
        end
        d2r_ack = 1'b1; tick(); d2r_ack = 1'b0;
        chk("rd1 done", d2r_stb, 0);

        // Shadow write to layer 1 reaches active only at frame start
        send(8'h2C, 40'h1, 1);
        send(8'h20, 40'h1000, 1);
        chk("l1 pre-commit", cfg_base_addr[77:39], 0);
        send(8'h2A, 40'h0, 1);
        tick(); tick();
        chk("l1 armed", cfg_base_addr[77:39], 0);
        pulse_fs();
        chk("l1 committed", cfg_base_addr[77:39], 39'h1000);
        chk("l0 untouched", cfg_base_addr[38:0], 0);

        // No commit -> frame starts ignored; COMMIT coinciding with frame start arms only
        send(8'h20, 40'h2000, 1);
        for (int i = 0; i < 3; i++) begin
            pulse_fs(); tick();
        end
        chk("no commit", cfg_base_addr[77:39], 39'h1000);
        r2d_stb = 1'b1; r2d_cmd = 8'h2A; r2d_ptr = '0; frame_start = 1'b1;
        tick();
        r2d_stb = 1'b0; frame_start = 1'b0;
        chk("commit+fs", cfg_base_addr[77:39], 39'h1000);
        tick();
        pulse_fs();
        chk("next fs", cfg_base_addr[77:39], 39'h2000);

        // FIFO fill to full, blocked push, pop releases it
        for (int i = 0; i < 16; i++) send(8'h26, 40'(i), 1);
        chk("fifo head", char_dat, 0);
        r2d_stb = 1'b1; r2d_cmd = 8'h26; r2d_ptr = 40'd16;
        #1 chk("full ack", r2d_ack, 0);
        tick();
        char_ack = 1'b1;
        #1 chk("full+pop ack", r2d_ack, 0);
        tick();
        char_ack = 1'b0;
        #1 chk("after pop ack", r2d_ack, 1);
        tick();
        r2d_stb = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("pop stb", char_stb, 1);
            chk("pop order", char_dat, k);
            char_ack = 1'b1; tick(); char_ack = 1'b0;
        end
        chk("fifo drained", char_stb, 0);

        // Second READ_REG stalls while the first reply is outstanding
        r2d_stb = 1'b1; r2d_cmd = 8'h2B; r2d_ptr = 40'h023;
        #1 chk("rdA ack", r2d_ack, 1);
        tick();
        r2d_ptr = 40'h120;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rdB stalled", r2d_ack, 0);
            chk("rdA ptr", d2r_ptr, 272);
            tick();
        end
        d2r_ack = 1'b1;
        #1 chk("rdB stall@ack", r2d_ack, 0);
        tick();
        d2r_ack = 1'b0;
        #1 chk("rdB ack", r2d_ack, 1);
        tick();
        r2d_stb = 1'b0;
        chk("rdB stb", d2r_stb, 1);
        chk("rdB ptr", d2r_ptr, 40'h2000);
        d2r_ack = 1'b1; tick(); d2r_ack = 1'b0;

        // Soft reset mid-operation
        for (int i = 0; i < 3; i++) send(8'h26, 40'(8'hC0 + i), 1);
        send(8'h20, 40'h3333, 1);
        send(8'h2A, 40'h0, 1);
        send(8'h2B, 40'h020, 1);
        chk("pre srst busy", d2r_stb, 1);
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        chk("srst char_stb", char_stb, 0);
        chk("srst d2r_stb", d2r_stb, 0);
        chk("srst d2r_ptr", d2r_ptr, 0);
        chk("srst base1", cfg_base_addr[77:39], 0);
        chk("srst ena", cfg_layer_ena, 2'b01);
        send(8'h20, 40'h4444, 1);
        pulse_fs();
        chk("srst disarmed", cfg_base_addr[38:0], 0);

        // Read-back table
        vt[0]  = '{8'h25, 40'h1,          11'h025, 40'd1};
        vt[1]  = '{8'h27, 40'h3,          11'h027, 40'd1};
        vt[2]  = '{8'h28, 40'h2,          11'h028, 40'd0};
        vt[3]  = '{8'h00, 40'h0,          11'h030, 40'd0};
        vt[4]  = '{8'h00, 40'h0,          11'h522, 40'd0};
        vt[5]  = '{8'h00, 40'h0,          11'h021, 40'd2048};
        vt[6]  = '{8'h00, 40'h0,          11'h123, 40'd272};
        vt[7]  = '{8'h00, 40'h0,          11'h029, 40'd1};
        vt[8]  = '{8'h00, 40'h0,          11'h129, 40'd0};
        vt[9]  = '{8'h2C, 40'h7,          11'h020, 40'd0};
        vt[10] = '{8'h21, 40'hFFFF_F123,  11'h021, 40'd2048};
        vt[11] = '{8'h00, 40'h0,          11'h122, 40'd480};
        for (int i = 0; i < 12; i++) begin
            send(vt[i].wcmd, vt[i].wptr, 1);
            send(8'h2B, {29'b0, vt[i].rsel}, 1);
            chk("tbl stb", d2r_stb, 1);
            chk($sformatf("tbl[%0d] ptr", i), d2r_ptr, vt[i].exp);
            d2r_ack = 1'b1; tick(); d2r_ack = 1'b0;
        end
        chk("tbl globals", {cfg_text_ena, cfg_h_pol, cfg_v_pol}, 3'b110);
        send(8'h2A, 40'h0, 1);
        pulse_fs();
        chk("tbl commit base", cfg_base_addr[38:0], 39'h4444);
        chk("tbl commit ph", cfg_ph_width[15:0], 16'h0123);

        // Randomized run against the reference model
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        m_reset();
        for (int n = 0; n < 600; n++) begin
            int r;
            stb = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r < 13) c = 8'h20 + 8'(r);
            else if (r < 17) c = 8'h26;
            else if (r == 17) c = 8'h2F;
            else c = 8'h00;
            p = {8'($urandom()), 32'($urandom())};
            if (c == 8'h2B) p[10:0] = {3'($urandom_range(0, 2)), 8'h20 + 8'($urandom_range(0, 10))};
            fs = ($urandom_range(0, 7) == 0);
            ca = ($urandom_range(0, 3) == 0);
            da = ($urandom_range(0, 2) == 0);
            sr = ($urandom_range(0, 99) == 0);
            r2d_stb = stb; r2d_cmd = c; r2d_ptr = p;
            frame_start = fs; char_ack = ca; d2r_ack = da; soft_rst = sr;
            #1;
            ea = m_ack(stb, c);
            chk("rnd ack", r2d_ack, ea);
            m_step(sr, ea, c, p, fs, ca, da);
            tick();
            for (int l = 0; l < NL; l++) begin
                chk("rnd base", cfg_base_addr[39*l +: 39], m_act[l].base);
                chk("rnd ph", cfg_ph_width[16*l +: 16], m_act[l].ph);
                chk("rnd lw", cfg_lo_width[16*l +: 16], m_act[l].lw);
                chk("rnd lh", cfg_lo_height[16*l +: 16], m_act[l].lh);
                chk("rnd mode", cfg_mode[2*l +: 2], m_act[l].mode);
                chk("rnd ena", cfg_layer_ena[l], m_act[l].ena);
            end
            chk("rnd glob", {cfg_text_ena, cfg_h_pol, cfg_v_pol}, {m_text, m_hpol, m_vpol});
            chk("rnd char_stb", char_stb, m_fifo.size() > 0);
            if (m_fifo.size() > 0) chk("rnd char_dat", char_dat, m_fifo[0]);
            chk("rnd d2r_stb", d2r_stb, m_busy);
            if (m_busy) begin
                chk("rnd d2r_cmd", d2r_cmd, 8'h2F);
                chk("rnd d2r_ptr", d2r_ptr, m_rptr);
            end
        end
        r2d_stb = 1'b0; frame_start = 1'b0; char_ack = 1'b0; d2r_ack = 1'b0; soft_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
